ram_infr: RTL and testbench



---
 rtl/ram_infr.sv | 47 ++++
 tb/tb_ram_infr.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ram_infr.sv
// Purpose: single-port RAM, synchronous write, registered read-first output port.
// Latency: write stored at the edge with we=1; read data valid one edge after a is sampled.
// Backpressure: none; a read or write is accepted on every edge.
module ram_infr #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;

  // Next state: the read samples the pre-write word (read-first), the write updates one word.
  always_comb begin
    mem_d  = mem_q;
    dout_d = mem_q[a];
    if (we) begin
      mem_d[a] = di;
    end
  end

  // State update; reset clears the output register and every word without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      mem_q  <= mem_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_ram_infr.sv
// Bench for ram_infr: directed scenarios plus random traffic, checked every cycle
// against an array model with read-before-write semantics and async clear.
// Literal expectations pin the model on the directed scenarios.
module tb_ram_infr;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic [4:0] a;
  logic [3:0] di;
  logic [3:0] dout;

  int total = 0;
  int bad   = 0;

  logic [3:0] model [32];
  logic [3:0] exp_do;

  ram_infr #(.ADDR_WIDTH(5), .DATA_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .a    (a),
    .di   (di),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  // Model reacts to asynchronous reset immediately.
  always @(negedge rst_n) begin
    for (int i = 0; i < 32; i++) model[i] = 4'd0;
    exp_do = 4'd0;
  end

  // Model update at every edge, then compare shortly after the edge.
  always @(posedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 4'd0;
      e = 4'd0;
    end else begin
      e = model[a];
      if (we) model[a] = di;
    end
    exp_do = e;
    #1;
    chk("cycle", dout, exp_do);
  end

  // One cycle: drive on the falling edge, return shortly after the next rising edge.
  task automatic step(input logic w, input logic [4:0] ad, input logic [3:0] d);
    @(negedge clk);
    we = w;
    a  = ad;
    di = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [4:0] ad;
    rst_n = 1'b0;
    we    = 1'b0;
    a     = 5'd0;
    di    = 4'd0;
    #1;
    chk("reset_async", dout, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_held", dout, 4'b0000);

    // Release reset and idle.
    @(negedge clk);
    rst_n = 1'b1;
    a     = 5'd10;
    step(1'b0, 5'd10, 4'd0);
    chk("idle_a10", dout, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      ad = i[4:0];
      step(1'b0, ad, 4'd0);
      chk("post_reset_sweep", dout, 4'b0000);
    end

    // Two writes and read-back.
    step(1'b1, 5'd3, 4'b1001);
    step(1'b1, 5'd7, 4'b1100);
    step(1'b0, 5'd3, 4'd0);
    chk("read_3", dout, 4'b1001);
    step(1'b0, 5'd7, 4'd0);
    chk("read_7", dout, 4'b1100);
    step(1'b0, 5'd10, 4'd0);
    chk("read_10", dout, 4'b0000);

    // Read-during-write at the same address returns the old word, new word next edge.
    step(1'b1, 5'd3, 4'b0110);
    chk("rdw_old", dout, 4'b1001);
    step(1'b0, 5'd3, 4'd0);
    chk("rdw_new", dout, 4'b0110);

    // Output register holds while the address moves between edges.
    #1 a = 5'd7;
    #1 chk("hold_a7", dout, 4'b0110);
    a = 5'd0;
    #1 chk("hold_a0", dout, 4'b0110);

    // Async reset pulse between edges; a write attempted during reset is dropped.
    step(1'b0, 5'd7, 4'd0);
    chk("pre_reset_7", dout, 4'b1100);
    rst_n = 1'b0;
    #1 chk("async_clear", dout, 4'b0000);
    @(negedge clk);
    we = 1'b1;
    a  = 5'd5;
    di = 4'hF;
    @(posedge clk);
    #2 chk("reset_write_dropped_do", dout, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    step(1'b0, 5'd3, 4'd0);
    chk("after_reset_3", dout, 4'b0000);
    step(1'b0, 5'd7, 4'd0);
    chk("after_reset_7", dout, 4'b0000);
    step(1'b0, 5'd5, 4'd0);
    chk("after_reset_5", dout, 4'b0000);

    // Full sweep: write addr ^ 4'hA everywhere, then read back.
    for (int i = 0; i < 32; i++) begin
      ad = i[4:0];
      step(1'b1, ad, ad[3:0] ^ 4'hA);
    end
    for (int i = 0; i < 32; i++) begin
      ad = i[4:0];
      step(1'b0, ad, 4'd0);
      chk("sweep_readback", dout, ad[3:0] ^ 4'hA);
    end

    // Random traffic with occasional reset pulses; the per-cycle compare does the checking.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 63) == 0) begin
        #1 rst_n = 1'b0;
        #1 chk("rand_async_clear", dout, 4'b0000);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
